alu_share_ctrl: RTL
===================

# alu_share_ctrl

Sequencer and round-robin arbiter that lets two requesters share the single combinational `alu`. It registers the winning request onto the ALU ports, captures `Result`/`Flags` one cycle later, and returns them through a valid/ready response channel. It also owns the architectural flags register, so `FnADC`/`FnSUC` carry chaining sees the carry of the last flag-setting operation. It sits between the CPU datapath decode stage (requester 0) and the address/auxiliary unit (requester 1), and it instantiates `alu` directly.

## Interface
- `GRANT_INIT`, default 0: requester holding highest priority after reset.
- `LOCK_TIMEOUT`, default 8: idle cycles before a held lock is force-released. Meaningful only with the lock feature.
- One clock; reset is synchronous and active-high.
- `Clock`  in  1  rising-edge clock.
- `Reset`  in  1  synchronous, active-high reset.
- `ReqValid`  in  [1:0]  request valid, per requester.
- `ReqReady`  out  [1:0]  request accepted, per requester; at most one bit high.
- `ReqAluOp0`, `ReqAluOp1`  in  alu_functions_t  operation per requester.
- `ReqA0`, `ReqB0`, `ReqA1`, `ReqB1`  in  16  operands per requester.
- `ReqUseC`  in  [1:0]  CarryIn = stored C flag, else 0.
- `ReqSetF`  in  [1:0]  write ALU flags into `FlagsReg`.
- `ReqLock`  in  [1:0]  keep grant for the next operation. Present only with the lock feature.
- `RspValid`  out  [1:0]  response valid; one-hot owner.
- `RspReady`  in  [1:0]  response consumed.
- `RspResult`  out  16  captured `Result`.
- `RspFlags`  out  4  captured `Flags`, indexed by `FLAGS_Z/C/N/V`.
- `FlagsReg`  out  4  architectural flags.

## Operation
- States: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE**
  - Arbitrate among `ReqValid`.
  - Priority is round-robin; the last granted requester gets lowest priority.
  - `ReqReady[g]` is combinational and asserted only for the winner `g`.
  - On `ReqValid[g] & ReqReady[g]`:
    - latch op, operands, UseC, SetF and owner into the issue registers;
    - go to EXEC.
- **EXEC**
  - `AluOp`/`Op1`/`Op2` are driven from the issue registers.
  - `CarryIn` = `UseC ? FlagsReg[FLAGS_C] : 0`.
  - At the clock edge, capture `Result`/`Flags` into `RspResult`/`RspFlags`.
  - If SetF, load `FlagsReg` with `Flags`.
  - Go to RESP.
- **RESP**
  - `RspValid[owner]` = 1 and is held until `RspReady[owner]`.
  - `RspReady` of the non-owner is ignored.
  - On handshake, update the round-robin pointer and go to IDLE.
- `ReqReady` = 0 in EXEC and RESP.
- Outside EXEC the ALU inputs hold their last issued values; no gating.
- **Reset values**
  - state IDLE;
  - `ReqReady` = 0, `RspValid` = 0;
  - `RspResult` = 0, `RspFlags` = 0, `FlagsReg` = 0;
  - `AluOp` = `FnA`, `Op1` = 0, `Op2` = 0, `CarryIn` = 0;
  - priority pointer = `GRANT_INIT`;
  - lock cleared.
- **Reset mid-operation:** the in-flight transaction is discarded with no response. `FlagsReg` still returns to 0.
- **Simultaneous events**
  - Both valid in IDLE: the priority holder wins.
  - A `ReqValid` drop in IDLE before acceptance is legal; no state change.

## Timing
- Request accepted at edge t. ALU evaluates during cycle t+1. `RspValid` rises at t+2.
- Minimum latency is 2 cycles from accept to response.
- Maximum throughput is 1 operation per 3 cycles, when `RspReady` is held high.
- The next accept comes in the cycle after the response handshake.
- A `FlagsReg` update is visible to `CarryIn` of the next issued operation. Back-to-back `FnADD`(SetF) then `FnADC`(UseC) therefore chains correctly.

## Configuration
- `ALU_SHARE_LOCK_EN`
- **Defined**
  - `ReqLock` exists.
  - Accepting a request with `ReqLock[g]` = 1 sets lock owner `g`.
  - While locked, IDLE grants only `g`.
  - The lock clears when `g` is accepted with `ReqLock` = 0.
  - The lock also clears after `LOCK_TIMEOUT` consecutive IDLE cycles with `ReqValid[g]` = 0. The counter resets on every accept.
  - Used for 32-bit ADD/ADC pairs without interleaved flag corruption.
- **Undefined:** the port and lock logic are absent, and arbitration is pure round-robin.

## Test plan
- **Single op:** req0 `FnADD` 0x1234 + 0x0101, SetF → `RspValid[0]` at t+2, `RspResult` = 0x1335; `FlagsReg` Z=0, C=0.
- **Carry chain:**
  - req0 `FnADD` 0xFFFF + 0x0001, SetF → Result 0x0000, Z=1, C=1.
  - Then `FnADC` 0x0000 + 0x0000, UseC → Result 0x0001.
- **Contention:**
  - Both valid every cycle, `GRANT_INIT` = 0 → grants alternate 0,1,0,1.
  - Each `RspValid` goes only to its owner.
- **Backpressure:** `RspReady` low for 5 cycles in RESP → `RspValid`/`RspResult` stable, no new `ReqReady`.
- **Reset:** assert `Reset` during EXEC → next cycle state IDLE, `RspValid` = 0, `FlagsReg` = 0, no response delivered.
- **Lock** (`ALU_SHARE_LOCK_EN`):
  - req1 locks with both valid → three consecutive grants to 1.
  - Then req1 idles 8 cycles → req0 granted.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one combinational ALU between two requesters.
// A round-robin arbiter issues one operation at a time onto the ALU. The
// result comes back on a valid/ready response channel. The block also holds
// the architectural flags register, which carry-chained ops read.
// Optional feature macro: ALU_SHARE_LOCK_EN (lets a requester hold its grant).

package alu_pkg;

  typedef enum logic [3:0] {
    FnA   = 4'd0,
    FnB   = 4'd1,
    FnADD = 4'd2,
    FnADC = 4'd3,
    FnSUB = 4'd4,
    FnSUC = 4'd5,
    FnAND = 4'd6,
    FnOR  = 4'd7,
    FnXOR = 4'd8,
    FnNOT = 4'd9,
    FnSHL = 4'd10,
    FnSHR = 4'd11
  } alu_functions_t;

  localparam int FLAGS_Z = 0;
  localparam int FLAGS_C = 1;
  localparam int FLAGS_N = 2;
  localparam int FLAGS_V = 3;

endpackage

// 16-bit combinational ALU with Z/C/N/V flags
module alu
  import alu_pkg::*;
(
  input  alu_functions_t AluOp,
  input  logic [15:0]    Op1,
  input  logic [15:0]    Op2,
  input  logic           CarryIn,
  output logic [15:0]    Result,
  output logic [3:0]     Flags
);

  logic [16:0] w_sum;
  logic        w_carry;
  logic        w_ovf;

  // Subtraction is A + ~B + 1, so C=1 means "no borrow"
  always_comb begin
    w_sum   = 17'd0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (AluOp)
      FnA:   w_sum = {1'b0, Op1};
      FnB:   w_sum = {1'b0, Op2};
      FnADD: begin
        w_sum   = {1'b0, Op1} + {1'b0, Op2};
        w_carry = w_sum[16];
        w_ovf   = (Op1[15] == Op2[15]) && (w_sum[15] != Op1[15]);
      end
      FnADC: begin
        w_sum   = {1'b0, Op1} + {1'b0, Op2} + {16'd0, CarryIn};
        w_carry = w_sum[16];
        w_ovf   = (Op1[15] == Op2[15]) && (w_sum[15] != Op1[15]);
      end
      FnSUB: begin
        w_sum   = {1'b0, Op1} + {1'b0, ~Op2} + 17'd1;
        w_carry = w_sum[16];
        w_ovf   = (Op1[15] != Op2[15]) && (w_sum[15] != Op1[15]);
      end
      FnSUC: begin
        w_sum   = {1'b0, Op1} + {1'b0, ~Op2} + {16'd0, CarryIn};
        w_carry = w_sum[16];
        w_ovf   = (Op1[15] != Op2[15]) && (w_sum[15] != Op1[15]);
      end
      FnAND: w_sum = {1'b0, Op1 & Op2};
      FnOR:  w_sum = {1'b0, Op1 | Op2};
      FnXOR: w_sum = {1'b0, Op1 ^ Op2};
      FnNOT: w_sum = {1'b0, ~Op1};
      FnSHL: begin
        w_sum   = {1'b0, Op1[14:0], 1'b0};
        w_carry = Op1[15];
      end
      FnSHR: begin
        w_sum   = {2'b00, Op1[15:1]};
        w_carry = Op1[0];
      end
      default: w_sum = {1'b0, Op1};
    endcase
  end

  // Result and flag packing
  always_comb begin
    Result          = w_sum[15:0];
    Flags           = 4'd0;
    Flags[FLAGS_Z]  = (w_sum[15:0] == 16'd0);
    Flags[FLAGS_C]  = w_carry;
    Flags[FLAGS_N]  = w_sum[15];
    Flags[FLAGS_V]  = w_ovf;
  end

endmodule

module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned GRANT_INIT = 0
`ifdef ALU_SHARE_LOCK_EN
  , parameter int unsigned LOCK_TIMEOUT = 8
`endif
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic [1:0]     ReqValid,
  output logic [1:0]     ReqReady,
  input  alu_functions_t ReqAluOp0,
  input  alu_functions_t ReqAluOp1,
  input  logic [15:0]    ReqA0,
  input  logic [15:0]    ReqB0,
  input  logic [15:0]    ReqA1,
  input  logic [15:0]    ReqB1,
  input  logic [1:0]     ReqUseC,
  input  logic [1:0]     ReqSetF,
`ifdef ALU_SHARE_LOCK_EN
  input  logic [1:0]     ReqLock,
`endif
  output logic [1:0]     RspValid,
  input  logic [1:0]     RspReady,
  output logic [15:0]    RspResult,
  output logic [3:0]     RspFlags,
  output logic [3:0]     FlagsReg
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t r_state;
  state_t w_nextState;

  // Issue registers: these drive the ALU directly and hold between ops
  alu_functions_t r_aluOp;
  logic [15:0]    r_op1;
  logic [15:0]    r_op2;
  logic           r_useC;
  logic           r_setF;
  logic           r_owner;

  logic [15:0]    r_rspResult;
  logic [3:0]     r_rspFlags;
  logic [3:0]     r_flagsReg;

  // r_prio names the requester that currently has highest priority
  logic           r_prio;

  logic           w_rrIdx;
  logic           w_grantIdx;
  logic [1:0]     w_reqReady;
  logic           w_accept;
  logic           w_rspDone;
  logic           w_carryIn;
  logic [15:0]    w_aluResult;
  logic [3:0]     w_aluFlags;

`ifdef ALU_SHARE_LOCK_EN
  localparam int LCW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  logic           r_lockActive;
  logic           r_lockOwner;
  logic [LCW-1:0] r_lockCnt;
`endif

  assign w_carryIn = r_useC & r_flagsReg[FLAGS_C];
  assign w_rspDone = (r_state == RESP) && RspReady[r_owner];

  alu uAlu (
    .AluOp   (r_aluOp),
    .Op1     (r_op1),
    .Op2     (r_op2),
    .CarryIn (w_carryIn),
    .Result  (w_aluResult),
    .Flags   (w_aluFlags)
  );

  // Round-robin pick: priority holder if it asks, otherwise the other one
  always_comb begin
    w_rrIdx = ReqValid[r_prio] ? r_prio : ~r_prio;
  end

  // A held lock pins the grant to its owner; otherwise plain round-robin
  always_comb begin
`ifdef ALU_SHARE_LOCK_EN
    if (r_lockActive) begin
      w_grantIdx = r_lockOwner;
    end else begin
      w_grantIdx = w_rrIdx;
    end
`else
    w_grantIdx = w_rrIdx;
`endif
  end

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: one issue, one ALU cycle, then wait for the owner
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = EXEC;
      EXEC:    w_nextState = RESP;
      RESP:    if (RspReady[r_owner]) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Handshake outputs: ready only for the winner in IDLE, valid only to owner
  always_comb begin
    w_reqReady = 2'b00;
    RspValid   = 2'b00;
    if ((r_state == IDLE) && !Reset && ReqValid[w_grantIdx]) begin
      w_reqReady = {w_grantIdx, ~w_grantIdx};
    end
    if (r_state == RESP) begin
      RspValid = {r_owner, ~r_owner};
    end
  end

  assign ReqReady = w_reqReady;
  assign w_accept = |w_reqReady;

  // Latch the winning request into the issue registers on accept
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_aluOp <= FnA;
      r_op1   <= 16'd0;
      r_op2   <= 16'd0;
      r_useC  <= 1'b0;
      r_setF  <= 1'b0;
      r_owner <= 1'b0;
    end else if (w_accept) begin
      r_aluOp <= w_grantIdx ? ReqAluOp1 : ReqAluOp0;
      r_op1   <= w_grantIdx ? ReqA1 : ReqA0;
      r_op2   <= w_grantIdx ? ReqB1 : ReqB0;
      r_useC  <= ReqUseC[w_grantIdx];
      r_setF  <= ReqSetF[w_grantIdx];
      r_owner <= w_grantIdx;
    end
  end

  // Capture the ALU output at the end of EXEC and update architectural flags
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_rspResult <= 16'd0;
      r_rspFlags  <= 4'd0;
      r_flagsReg  <= 4'd0;
    end else if (r_state == EXEC) begin
      r_rspResult <= w_aluResult;
      r_rspFlags  <= w_aluFlags;
      if (r_setF) begin
        r_flagsReg <= w_aluFlags;
      end
    end
  end

  assign RspResult = r_rspResult;
  assign RspFlags  = r_rspFlags;
  assign FlagsReg  = r_flagsReg;

  // The requester just served drops to lowest priority after its handshake
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_prio <= 1'(GRANT_INIT);
    end else if (w_rspDone) begin
      r_prio <= ~r_owner;
    end
  end

`ifdef ALU_SHARE_LOCK_EN
  // Lock tracking: set/clear on accept, force-release after idle owner cycles
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_lockActive <= 1'b0;
      r_lockOwner  <= 1'b0;
      r_lockCnt    <= '0;
    end else if (w_accept) begin
      r_lockCnt <= '0;
      if (ReqLock[w_grantIdx]) begin
        r_lockActive <= 1'b1;
        r_lockOwner  <= w_grantIdx;
      end else if (r_lockActive && (w_grantIdx == r_lockOwner)) begin
        r_lockActive <= 1'b0;
      end
    end else if ((r_state == IDLE) && r_lockActive && !ReqValid[r_lockOwner]) begin
      if (r_lockCnt == LCW'(LOCK_TIMEOUT - 1)) begin
        r_lockActive <= 1'b0;
        r_lockCnt    <= '0;
      end else begin
        r_lockCnt <= r_lockCnt + 1'b1;
      end
    end
  end
`endif

endmodule
